// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests under a 2-credit limit, queues responses in order for decode.
// Latency memory+1 cycle (no bypass); stalls issue when inflight+queued reaches 2; redirect flushes and drops stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  // pc keeps the raw target; alignment is applied where the address leaves the block
  logic [31:0] pc;

  logic [31:0] q_word [2];
  logic [31:0] q_pc   [2];
  logic        q_head;
  logic [1:0]  q_cnt;
  logic [1:0]  q_cnt_nxt;

  logic [31:0] a_addr [2];
  logic        a_head;
  logic [1:0]  inflight;
  logic [1:0]  inflight_nxt;
  logic [1:0]  drop_cnt;

  logic        credit;
  logic        accept;
  logic        q_push;
  logic        q_pop;
  logic        q_wr_idx;
  logic        a_wr_idx;

  assign credit         = ({1'b0, inflight} + {1'b0, q_cnt}) < 3'd2;
  assign imem_req_valid = !rst && !redirect_valid && credit;
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;

  assign q_push   = imem_rsp_valid && (drop_cnt == 2'd0) && !redirect_valid;
  assign q_pop    = inst_valid && inst_ready;
  assign q_wr_idx = q_head ^ q_cnt[0];
  assign a_wr_idx = a_head ^ inflight[0];

  assign inst_valid = !rst && (q_cnt != 2'd0);
  assign inst       = inst_valid ? q_word[q_head] : 32'h0;
  assign inst_pc    = inst_valid ? q_pc[q_head]   : 32'h0;

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !imem_rsp_valid)
      inflight_nxt = inflight + 2'd1;
    else if (!accept && imem_rsp_valid && (inflight != 2'd0))
      inflight_nxt = inflight - 2'd1;
  end

  always_comb begin
    q_cnt_nxt = q_cnt;
    case ({q_push, q_pop})
      2'b10:   q_cnt_nxt = q_cnt + 2'd1;
      2'b01:   q_cnt_nxt = q_cnt - 2'd1;
      default: q_cnt_nxt = q_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      q_head   <= 1'b0;
      q_cnt    <= 2'd0;
      a_head   <= 1'b0;
      inflight <= 2'd0;
      drop_cnt <= 2'd0;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc;
      else if (accept)
        pc <= pc + 32'd4;

      if (imem_rsp_valid && (inflight != 2'd0))
        a_head <= ~a_head;
      inflight <= inflight_nxt;

      // every response still owed at redirect time belongs to the abandoned path
      if (redirect_valid)
        drop_cnt <= inflight - {1'b0, imem_rsp_valid};
      else if (imem_rsp_valid && (drop_cnt != 2'd0))
        drop_cnt <= drop_cnt - 2'd1;

      if (redirect_valid) begin
        q_cnt <= 2'd0;
      end else begin
        if (q_pop)
          q_head <= ~q_head;
        q_cnt <= q_cnt_nxt;
      end
    end
  end

  // When full with a simultaneous pop, the write slot equals the slot being vacated.
  always_ff @(posedge clk) begin
    if (accept)
      a_addr[a_wr_idx] <= imem_req_addr;
    if (q_push) begin
      q_word[q_wr_idx] <= imem_rsp_data;
      q_pc[q_wr_idx]   <= a_addr[a_head];
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(q_push && !q_pop && (q_cnt == 2'd2)));
  assert property (@(posedge clk) disable iff (rst) drop_cnt <= inflight);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded by reset.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port imem_req_valid  output  1  fetch request present.
REQ-005 Port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 Port imem_req_addr  output  32  word address of the request.
REQ-007 Port imem_rsp_valid  input  1  response word present; responses return in order, one per accepted request, at least 1 cycle after acceptance.
REQ-008 Port imem_rsp_data  input  32  fetched instruction word.
REQ-009 Port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-010 Port redirect_pc  input  32  new fetch PC.
REQ-011 Port inst_valid  output  1  instruction available to decode.
REQ-012 Port inst_ready  input  1  decode consumes the instruction this cycle.
REQ-013 Port inst  output  32  instruction word, fed directly to the decode stage inst input.
REQ-014 Port inst_pc  output  32  PC of inst.

Function
REQ-015 The block SHALL hold a fetch PC register, a 2-entry in-order instruction queue {word, pc}, a 2-entry address FIFO of outstanding requests, an outstanding counter inflight (0..2) and a drop counter drop_cnt (0..2, drop_cnt <= inflight).
REQ-016 imem_req_addr SHALL equal the fetch PC with bits [1:0] always 2'b00.
REQ-017 imem_req_valid SHALL be 1 when (inflight + queue count) < 2, rst is 0, and redirect_valid is 0; otherwise 0.
REQ-018 A request is accepted when imem_req_valid & imem_req_ready; on acceptance PC <= PC + 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), its address is pushed to the address FIFO, and inflight increments.
REQ-019 While imem_req_valid is 1 and not accepted, imem_req_addr SHALL stay stable.
REQ-020 On imem_rsp_valid, inflight SHALL decrement and the address FIFO SHALL pop; if drop_cnt > 0 the word SHALL be discarded and drop_cnt decremented, otherwise {imem_rsp_data, popped address} SHALL be pushed to the queue.
REQ-021 A pushed entry SHALL become visible on inst/inst_pc no earlier than the next cycle (no combinational bypass); fetch-to-decode latency is therefore memory latency + 1 cycle.
REQ-022 inst_valid SHALL be 1 iff the queue is non-empty; inst/inst_pc SHALL show the head entry; the head SHALL pop on inst_valid & inst_ready.
REQ-023 Simultaneous push and pop SHALL be supported at any occupancy including full; the credit rule of REQ-017 guarantees the queue never overflows.
REQ-024 Redirect has priority over all other events: on redirect_valid the queue SHALL be emptied (a pop that cycle is ignored), PC <= {redirect_pc[31:2], 2'b00}, drop_cnt <= inflight - imem_rsp_valid, and any response that cycle SHALL be discarded.
REQ-025 After a redirect, the first request SHALL be issued the following cycle if credit allows, with address equal to the redirect target.
REQ-026 A redirect while drop_cnt > 0 SHALL apply the same REQ-024 rule (drops accumulate to total outstanding).
REQ-027 Instructions SHALL reach decode in program order with no duplication or loss outside of redirect flushes.

Reset
REQ-028 While rst is 1: PC <= RESET_PC, queue and address FIFO empty, inflight = 0, drop_cnt = 0, imem_req_valid = 0, inst_valid = 0, inst = 32'h0, inst_pc = 32'h0.
REQ-029 rst asserted mid-operation SHALL abandon all state; responses to requests issued before reset SHALL NOT be accepted by the bench (the memory is reset on the same rst).
REQ-030 The first cycle after rst falls, imem_req_valid SHALL be 1 with imem_req_addr = RESET_PC.

Verification
REQ-031 Reset release, ready=1, 1-cycle memory returning addr as data, inst_ready=1 -> inst_pc sequence 0,4,8,... with inst == inst_pc, first inst_valid 2 cycles after first request.
REQ-032 inst_ready held 0 for 10 cycles -> exactly 2 entries queued (pc 0,4), imem_req_valid = 0, no request beyond addr 4; release -> 0,4,8 in order, none lost.
REQ-033 Two requests outstanding (addr 8, 12) plus redirect_valid with redirect_pc = 32'h100 -> responses for 8 and 12 discarded, next inst_pc = 32'h100, queue empty the cycle after redirect.
REQ-034 redirect_pc = 32'h0000_0203 -> imem_req_addr = 32'h0000_0200.
REQ-035 imem_req_ready held 0 for 5 cycles -> imem_req_addr stable at pending value, PC not advanced.
REQ-036 PC = 32'hFFFF_FFFC accepted -> next imem_req_addr = 32'h0000_0000.
